buzzer_driver: RTL
==================

# buzzer_driver

Converts the buzzer control bits (`ctrl_en`, `ctrl_buzz`) into the square-wave drive for the board buzzer pin. Sits directly downstream of the buzzer bus interface. Generates a fixed-frequency tone from the system clock and stretches short beep requests to a minimum audible duration. Disabling the buzzer mutes it immediately.

## Interface
- `CLK_FREQ_HZ`, default 50_000_000: system clock frequency.
- `TONE_HZ`, default 2_000: output tone frequency. `HALF_PERIOD = CLK_FREQ_HZ / (2*TONE_HZ)` uses integer division and must be ≥ 1; an elaboration error is raised otherwise.
- `MIN_ON_CYCLES`, default 2_500_000: minimum tone duration in clock cycles, ≥ 1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-low; sampled on rising edge of `clk`.
- `ctrl_en`  in  1  buzzer enable; 0 = muted.
- `ctrl_buzz`  in  1  beep request level.
- `buzzer`  out  1  pin drive, registered.
- `active`  out  1  1 while in TONE state, registered.

## Operation
- Request is `req = ctrl_en && ctrl_buzz`. Inputs are synchronous to `clk` and need no synchronizer.
- The FSM has two states, IDLE and TONE.
- IDLE:
  - `buzzer=0`, `active=0`, counters held at 0.
  - If `req`=1, go to TONE: `buzzer←1`, `phase_cnt←0`, `hold_cnt←1`.
- TONE:
  - `phase_cnt` counts 0..HALF_PERIOD-1. At HALF_PERIOD-1 it wraps to 0 and `buzzer` toggles. Tone period is exactly 2·HALF_PERIOD cycles at 50% duty.
  - `hold_cnt` increments each cycle and saturates at MIN_ON_CYCLES. It has width `$clog2(MIN_ON_CYCLES+1)` and never wraps.
  - Exit to IDLE when `ctrl_en`=0 (immediate mute, overrides stretch).
  - Also exit to IDLE when `ctrl_buzz`=0 and `hold_cnt`==MIN_ON_CYCLES.
  - On exit: `buzzer←0`, `active←0`, counters←0.
  - `ctrl_buzz` dropping before the minimum is reached does not exit; the tone continues (stretch).
  - `ctrl_buzz` re-asserting during stretch has no effect: the tone stays continuous and the phase is not restarted.
- `phase_cnt` width is `$clog2(HALF_PERIOD)`, minimum 1 bit. When HALF_PERIOD=1, `buzzer` toggles every cycle.

## Timing
- Reset (`rst`=0 at an edge): state=IDLE, `buzzer`=0, `active`=0, `phase_cnt`=0, `hold_cnt`=0. Reset takes priority over all other inputs.
- Reset mid-tone: `buzzer` is 0 on the first edge with `rst`=0. After release, no tone until `req` is seen high again.
- Latency:
  - `req` sampled high at edge N gives `buzzer`=1 and `active`=1 after edge N.
  - First toggle occurs after edge N+HALF_PERIOD.
- Mute latency: `ctrl_en` sampled low at edge M gives `buzzer`=0 and `active`=0 after edge M, regardless of `hold_cnt` or phase.
- Minimum duration: a single-cycle `req` pulse keeps `active`=1 for exactly MIN_ON_CYCLES cycles.
- Stretch expiry with `ctrl_buzz` already high again: stays in TONE, no gap.
- Release after the minimum: `ctrl_buzz` sampled low at edge K, with `hold_cnt` already saturated, gives idle after edge K. Any phase may be truncated.
- Re-entry from IDLE always starts a fresh high half-period.

## Test plan
Bench parameters: CLK_FREQ_HZ=1000, TONE_HZ=100 (HALF_PERIOD=5), MIN_ON_CYCLES=20.

- Reset: hold `rst`=0 for 3 cycles with `ctrl_en`=`ctrl_buzz`=1. Expect `buzzer`=0 and `active`=0 throughout. After release, `buzzer`=1 one edge later.
- Continuous tone: `ctrl_en`=1, `ctrl_buzz`=1 for 40 cycles. Expect `buzzer` pattern 5×1, 5×0 repeating, and `active`=1. Drop `ctrl_buzz`: expect idle after the next edge.
- Stretch: one-cycle `ctrl_buzz` pulse with `ctrl_en`=1. Expect `active`=1 for exactly 20 cycles, and `buzzer` gives 2 full periods then returns to 0.
- Mute override: start a beep, and at cycle 7 drop `ctrl_en` (`ctrl_buzz` still 1). Expect `buzzer`=0 and `active`=0 after that edge, with no stretch.
- Re-assert during stretch: pulse `ctrl_buzz` at cycle 0, pulse again at cycle 12, then hold from cycle 18 to 30. Expect an uninterrupted tone with no phase reset, ending one edge after `ctrl_buzz` falls at cycle 30.
- Disabled request: `ctrl_en`=0, `ctrl_buzz`=1 for 50 cycles. Expect `buzzer`=0 and `active`=0 throughout.

Source files
------------

// File: rtl/buzzer_driver_if.sv
// Buzzer control/status bundle between the buzzer bus interface and the pin driver.
// The bus side drives the control bits; the driver returns pin drive and tone status.
interface buzzer_driver_if;
    logic ctrl_en;
    logic ctrl_buzz;
    logic buzzer;
    logic active;

    modport master (
        output ctrl_en,
        output ctrl_buzz,
        input  buzzer,
        input  active
    );

    modport slave (
        input  ctrl_en,
        input  ctrl_buzz,
        output buzzer,
        output active
    );
endinterface

// File: rtl/buzzer_driver.sv
// Square-wave buzzer drive with a minimum beep duration (stretch) and immediate mute.
// Two-state FSM: IDLE (silent) and TONE (fixed-frequency 50% duty output).
module buzzer_driver #(
    parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
    parameter int unsigned TONE_HZ       = 2_000,
    parameter int unsigned MIN_ON_CYCLES = 2_500_000
) (
    input  logic           clk,
    input  logic           rst,
    buzzer_driver_if.slave bus
);
    localparam int unsigned HALF_PERIOD = (TONE_HZ == 0) ? 0 : CLK_FREQ_HZ / (2 * TONE_HZ);
    localparam int unsigned PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int unsigned HW = (MIN_ON_CYCLES > 0) ? $clog2(MIN_ON_CYCLES + 1) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(HALF_PERIOD - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(MIN_ON_CYCLES);

    generate
        if (HALF_PERIOD < 1) begin : g_bad_half_period
            $error("buzzer_driver: CLK_FREQ_HZ / (2*TONE_HZ) must be at least 1");
        end
        if (MIN_ON_CYCLES < 1) begin : g_bad_min_on
            $error("buzzer_driver: MIN_ON_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        TONE = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_phase;
    logic [PW-1:0]   w_phase_nxt;
    logic [HW-1:0]   r_hold;
    logic [HW-1:0]   w_hold_nxt;
    logic            r_buzzer;
    logic            w_buzzer_nxt;
    logic            w_req;
    logic            w_hold_sat;

    assign w_req      = bus.ctrl_en && bus.ctrl_buzz;
    assign w_hold_sat = (r_hold == HOLD_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_phase  <= '0;
            r_hold   <= '0;
            r_buzzer <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_hold   <= w_hold_nxt;
            r_buzzer <= w_buzzer_nxt;
        end
    end

    // Mute (ctrl_en low) wins over stretch; release only once the hold is saturated.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IDLE) begin
            if (w_req) begin
                w_state_nxt = TONE;
            end
        end else begin
            if (!bus.ctrl_en || (!bus.ctrl_buzz && w_hold_sat)) begin
                w_state_nxt = IDLE;
            end
        end
    end

    // Counters and pin are cleared on every path into IDLE, so IDLE holds them at zero.
    always_comb begin
        w_phase_nxt  = '0;
        w_hold_nxt   = '0;
        w_buzzer_nxt = 1'b0;
        if (r_state == IDLE) begin
            if (w_state_nxt == TONE) begin
                w_buzzer_nxt = 1'b1;
                w_hold_nxt   = HW'(1);
            end
        end else if (w_state_nxt == TONE) begin
            w_hold_nxt = w_hold_sat ? r_hold : r_hold + 1'b1;
            if (r_phase == PHASE_LAST) begin
                w_phase_nxt  = '0;
                w_buzzer_nxt = ~r_buzzer;
            end else begin
                w_phase_nxt  = r_phase + 1'b1;
                w_buzzer_nxt = r_buzzer;
            end
        end
    end

    assign bus.buzzer = r_buzzer;
    assign bus.active = (r_state == TONE);
endmodule
